// File: rtl/stf_detect.sv
// Short-preamble (STF) detector.
// Delay-and-correlate over a 16-sample lag. A 16-sample sliding window sums
// the lag correlation C and the power P of the delayed samples. A sample
// matches when |C_re| + |C_im| >= 0.75 * P and P >= min_power. A run of
// max(min_plateau, 1) consecutive matches raises a one-cycle detection pulse.
//
// Handshake: a sample is accepted on a rising edge where enable and
// sample_in_strobe are both high. There is no backpressure. While enable is
// low, every register holds its value. Only the two one-cycle pulses drop to
// 0 while enable is low.
//
// Pipeline (the stage count is fixed; there are no bubbles):
//   edge 1 : delay line shift, capture s[n] and s[n-16]
//   edge 2 : exact lag products and delayed power
//   edge 3 : running window sums
//   edge 4 : match decision, FSM, registered outputs
// Edges are counted only while enable is high. Outputs for a sample appear
// in the 4th enabled cycle after the cycle that held its strobe.
module stf_detect (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        sample_in,
    input  logic               sample_in_strobe,
    input  logic [36:0]        min_power,
    input  logic [15:0]        min_plateau,
    output logic               short_preamble_detected,
    output logic signed [36:0] corr_re,
    output logic signed [36:0] corr_im,
    output logic               metric_strobe,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEARCH   = 2'd1,
        DETECTED = 2'd2
    } state_t;

    state_t state;
    assign state_dbg = state;

    // ---------------- stage 1: delay line and sample capture ----------------
    logic [31:0] dline [16];
    logic [31:0] cur1, old1;
    logic        v1, e1;

    // Shift the 16-deep delay line on each accepted sample. Pair each new
    // sample with the sample 16 before it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) dline[i] <= '0;
            cur1 <= '0;
            old1 <= '0;
            v1   <= 1'b0;
            e1   <= 1'b0;
        end else if (enable) begin
            v1 <= sample_in_strobe;
            e1 <= sample_in_strobe && (state != FILL);
            if (sample_in_strobe) begin
                cur1     <= sample_in;
                old1     <= dline[15];
                dline[0] <= sample_in;
                for (int i = 1; i < 16; i++) dline[i] <= dline[i-1];
            end
        end
    end

    // ---------------- stage 2: exact products ----------------
    // Operands are sign-extended to 33 bits so every product is exact. The
    // largest magnitude is 2 * 2^30, which fits 33-bit signed.
    logic signed [32:0] ci_x, cq_x, oi_x, oq_x;
    logic signed [32:0] p_re_c, p_im_c;
    logic        [32:0] q_c;

    assign ci_x = {{17{cur1[31]}}, cur1[31:16]};
    assign cq_x = {{17{cur1[15]}}, cur1[15:0]};
    assign oi_x = {{17{old1[31]}}, old1[31:16]};
    assign oq_x = {{17{old1[15]}}, old1[15:0]};

    assign p_re_c = ci_x * oi_x + cq_x * oq_x;
    assign p_im_c = cq_x * oi_x - ci_x * oq_x;
    assign q_c    = $unsigned(oi_x * oi_x + oq_x * oq_x);

    logic signed [32:0] p_re2, p_im2;
    logic        [32:0] q2;
    logic               v2, e2;

    // Register the per-sample terms.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_re2 <= '0;
            p_im2 <= '0;
            q2    <= '0;
            v2    <= 1'b0;
            e2    <= 1'b0;
        end else if (enable) begin
            v2 <= v1;
            e2 <= e1;
            if (v1) begin
                p_re2 <= p_re_c;
                p_im2 <= p_im_c;
                q2    <= q_c;
            end
        end
    end

    // ---------------- stage 3: running window sums ----------------
    logic signed [32:0] hist_re [16];
    logic signed [32:0] hist_im [16];
    logic        [32:0] hist_q  [16];
    logic signed [36:0] c_re, c_im;
    logic        [36:0] pw;
    logic               v3, e3;

    // Add the newest term and drop the term 16 samples older. The sums stay
    // exact, so wrap-around cannot occur within 37 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                hist_re[i] <= '0;
                hist_im[i] <= '0;
                hist_q[i]  <= '0;
            end
            c_re <= '0;
            c_im <= '0;
            pw   <= '0;
            v3   <= 1'b0;
            e3   <= 1'b0;
        end else if (enable) begin
            v3 <= v2;
            e3 <= e2;
            if (v2) begin
                c_re <= c_re + {{4{p_re2[32]}}, p_re2} - {{4{hist_re[15][32]}}, hist_re[15]};
                c_im <= c_im + {{4{p_im2[32]}}, p_im2} - {{4{hist_im[15][32]}}, hist_im[15]};
                pw   <= pw + {4'b0000, q2} - {4'b0000, hist_q[15]};
                hist_re[0] <= p_re2;
                hist_im[0] <= p_im2;
                hist_q[0]  <= q2;
                for (int i = 1; i < 16; i++) begin
                    hist_re[i] <= hist_re[i-1];
                    hist_im[i] <= hist_im[i-1];
                    hist_q[i]  <= hist_q[i-1];
                end
            end
        end
    end

    // ---------------- stage 4: match decision and FSM ----------------
    logic [36:0] abs_re, abs_im;
    logic [37:0] mag;
    logic [39:0] mag4, pow3;
    logic        match;
    logic [15:0] plateau, plateau_next, plateau_lim;
    logic [5:0]  fill_cnt;

    assign abs_re = c_re[36] ? $unsigned(-c_re) : $unsigned(c_re);
    assign abs_im = c_im[36] ? $unsigned(-c_im) : $unsigned(c_im);
    assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
    assign mag4   = {mag, 2'b00};
    assign pow3   = {3'b000, pw} + {2'b00, pw, 1'b0};
    assign match  = (mag4 >= pow3) && (pw >= min_power);

    assign plateau_lim  = (min_plateau == 16'd0) ? 16'd1 : min_plateau;
    assign plateau_next = !match ? 16'd0 :
                          (plateau == 16'hFFFF) ? plateau : plateau + 16'd1;

    // Fill counting, plateau tracking, detection and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= FILL;
            fill_cnt                <= '0;
            plateau                 <= '0;
            short_preamble_detected <= 1'b0;
            metric_strobe           <= 1'b0;
            corr_re                 <= '0;
            corr_im                 <= '0;
        end else begin
            short_preamble_detected <= 1'b0;
            metric_strobe           <= 1'b0;
            if (enable) begin
                if (state == FILL && sample_in_strobe) begin
                    fill_cnt <= fill_cnt + 6'd1;
                    if (fill_cnt == 6'd31) state <= SEARCH;
                end
                if (v3 && e3) begin
                    metric_strobe <= 1'b1;
                    plateau       <= plateau_next;
                    case (state)
                        SEARCH: begin
                            if (plateau_next >= plateau_lim) begin
                                short_preamble_detected <= 1'b1;
                                corr_re                 <= c_re;
                                corr_im                 <= c_im;
                                state                   <= DETECTED;
                            end
                        end
                        DETECTED: begin
                            if (!match) state <= SEARCH;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_stf_detect.sv
// Directed bench for stf_detect. A direct-sum reference model gives the
// expected match runs. Pulse timing is measured in enabled clock edges from
// the accepting edge of each strobe.
module tb_stf_detect;

    logic               clock;
    logic               reset;
    logic               enable;
    logic [31:0]        sample_in;
    logic               sample_in_strobe;
    logic [36:0]        min_power;
    logic [15:0]        min_plateau;
    logic               short_preamble_detected;
    logic signed [36:0] corr_re;
    logic signed [36:0] corr_im;
    logic               metric_strobe;
    logic [1:0]         state_dbg;

    stf_detect dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .sample_in               (sample_in),
        .sample_in_strobe        (sample_in_strobe),
        .min_power               (min_power),
        .min_plateau             (min_plateau),
        .short_preamble_detected (short_preamble_detected),
        .corr_re                 (corr_re),
        .corr_im                 (corr_im),
        .metric_strobe           (metric_strobe),
        .state_dbg               (state_dbg)
    );

    // ---------------- clock/reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One period of the 802.11 short training field, I in [31:16], Q in [15:0].
    logic [31:0] stf_tab [16] = '{
        32'hfd0efd0e, 32'h0873ffdf, 32'h00d5050e, 32'hf6d900d5,
        32'hfa1d0000, 32'hf6d900d5, 32'h00d5050e, 32'h0873ffdf,
        32'hfd0efd0e, 32'hffdf0873, 32'h050e00d5, 32'h00d5f6d9,
        32'h0000fa1d, 32'h00d5f6d9, 32'h050e00d5, 32'hffdf0873
    };

    logic [31:0] stream [0:1023];
    int          acc_edge [0:1023];
    int          acc_cnt, en_edges, ms_cnt, first_ms_edge;
    int          pulse_q[$];
    logic [31:0] exp_q[$];
    longint      exp_cre, exp_cim;
    int          tests, fails;

    // Enabled-edge counter and accept-edge log.
    always @(posedge clock) begin
        if (reset) begin
            en_edges = 0;
            acc_cnt  = 0;
        end else if (enable) begin
            en_edges = en_edges + 1;
            if (sample_in_strobe && acc_cnt < 1024) begin
                acc_edge[acc_cnt] = en_edges;
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    // Output observer, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            ms_cnt = 0;
            first_ms_edge = -1;
            pulse_q.delete();
        end else begin
            if (metric_strobe === 1'b1) begin
                if (ms_cnt == 0) first_ms_edge = en_edges;
                ms_cnt = ms_cnt + 1;
            end
            if (short_preamble_detected === 1'b1) pulse_q.push_back(en_edges);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Direct windowed sums per evaluated sample (no running state). The
    // indices of expected pulses go to exp_q. The correlation of the last
    // pulse goes to exp_cre/exp_cim.
    task automatic model_run(input int n, input int mpl, input longint mpw);
        int cnt, lim, st;
        exp_q.delete();
        exp_cre = 0;
        exp_cim = 0;
        cnt = 0;
        st  = 0;
        lim = (mpl == 0) ? 1 : mpl;
        for (int i = 32; i < n; i++) begin
            longint cr, cim, pp, mag;
            bit m;
            cr = 0; cim = 0; pp = 0;
            for (int k = i - 15; k <= i; k++) begin
                longint a_i, a_q, b_i, b_q;
                a_i = longint'($signed(stream[k][31:16]));
                a_q = longint'($signed(stream[k][15:0]));
                b_i = longint'($signed(stream[k-16][31:16]));
                b_q = longint'($signed(stream[k-16][15:0]));
                cr  += a_i * b_i + a_q * b_q;
                cim += a_q * b_i - a_i * b_q;
                pp  += b_i * b_i + b_q * b_q;
            end
            mag = ((cr < 0) ? -cr : cr) + ((cim < 0) ? -cim : cim);
            m = (4 * mag >= 3 * pp) && (pp >= mpw);
            if (m) begin
                if (cnt < 65535) cnt++;
            end else begin
                cnt = 0;
            end
            if (st == 0 && cnt >= lim) begin
                exp_q.push_back(32'(i));
                exp_cre = cr;
                exp_cim = cim;
                st = 1;
            end else if (st == 1 && !m) begin
                st = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b1;
        sample_in_strobe = 1'b0;
        sample_in = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_stf(input int start, input int count);
        for (int j = 0; j < count; j++) stream[start + j] = stf_tab[j % 16];
    endtask

    task automatic load_zero(input int start, input int count);
        for (int j = 0; j < count; j++) stream[start + j] = 32'h0;
    endtask

    // One strobe every 'gap' cycles. After strobe 'dis_at', enable drops for
    // 'dis_len' cycles. Then 'tail' idle enabled cycles follow.
    task automatic send_stream(input int n, input int gap, input int dis_at,
                               input int dis_len, input int tail);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            sample_in_strobe = 1'b1;
            sample_in = stream[i];
            @(negedge clock);
            sample_in_strobe = 1'b0;
            sample_in = '0;
            if (i == dis_at) begin
                enable = 1'b0;
                repeat (dis_len) @(negedge clock);
                enable = 1'b1;
            end
            repeat (gap - 1) @(negedge clock);
        end
        enable = 1'b1;
        repeat (tail) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        min_power = 37'd1;
        min_plateau = 16'd32;
        do_reset();
        tests++; if (short_preamble_detected !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", short_preamble_detected); end
        tests++; if (metric_strobe !== 1'b0) begin fails++; $display("FAIL reset_metric: got %b want 0", metric_strobe); end
        tests++; if (corr_re !== 37'd0) begin fails++; $display("FAIL reset_corr_re: got %0d want 0", corr_re); end
        tests++; if (corr_im !== 37'd0) begin fails++; $display("FAIL reset_corr_im: got %0d want 0", corr_im); end
        tests++; if (state_dbg !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        load_stf(0, 32);
        send_stream(32, 1, -1, 0, 8);
        tests++; if (ms_cnt !== 0) begin fails++; $display("FAIL fill_no_metric: got %0d want 0", ms_cnt); end
        tests++; if (pulse_q.size() !== 0) begin fails++; $display("FAIL fill_no_pulse: got %0d want 0", pulse_q.size()); end
        tests++; if (state_dbg !== 2'd1) begin fails++; $display("FAIL fill_to_search: got %0d want 1", state_dbg); end
    endtask

    task automatic test_stf_single(input int gap, input int dis_at, input int dis_len);
        min_power = 37'd1;
        min_plateau = 16'd32;
        load_stf(0, 160);
        model_run(160, 32, 1);
        do_reset();
        send_stream(160, gap, dis_at, dis_len, 8);
        tests++; if (pulse_q.size() !== 1) begin fails++; $display("FAIL stf_pulse_count gap%0d: got %0d want 1", gap, pulse_q.size()); end
        if (pulse_q.size() >= 1) begin
            tests++; if (pulse_q[0] !== acc_edge[63] + 3) begin fails++; $display("FAIL stf_pulse_time gap%0d: got edge %0d want %0d", gap, pulse_q[0], acc_edge[63] + 3); end
        end
        tests++; if (corr_re !== exp_cre[36:0]) begin fails++; $display("FAIL stf_corr_re gap%0d: got %0d want %0d", gap, corr_re, exp_cre); end
        tests++; if (corr_im !== 37'd0) begin fails++; $display("FAIL stf_corr_im gap%0d: got %0d want 0", gap, corr_im); end
        tests++; if (!(corr_re > 0)) begin fails++; $display("FAIL stf_corr_pos gap%0d: got %0d want >0", gap, corr_re); end
        tests++; if (ms_cnt !== 128) begin fails++; $display("FAIL stf_metric_count gap%0d: got %0d want 128", gap, ms_cnt); end
        tests++; if (first_ms_edge !== acc_edge[32] + 3) begin fails++; $display("FAIL stf_metric_time gap%0d: got %0d want %0d", gap, first_ms_edge, acc_edge[32] + 3); end
    endtask

    task automatic test_zeros();
        min_power = 37'd1;
        min_plateau = 16'd32;
        load_zero(0, 200);
        do_reset();
        send_stream(200, 1, -1, 0, 8);
        tests++; if (pulse_q.size() !== 0) begin fails++; $display("FAIL zeros_pulse: got %0d want 0", pulse_q.size()); end
        tests++; if (ms_cnt !== 168) begin fails++; $display("FAIL zeros_metric: got %0d want 168", ms_cnt); end
        tests++; if (corr_re !== 37'd0) begin fails++; $display("FAIL zeros_corr: got %0d want 0", corr_re); end
    endtask

    task automatic test_gap_recovery(input int mpl);
        min_power = 37'd1;
        min_plateau = 16'(mpl);
        load_stf(0, 48);
        load_zero(48, 16);
        load_stf(64, 80);
        model_run(144, mpl, 1);
        do_reset();
        send_stream(144, 1, -1, 0, 8);
        tests++; if (pulse_q.size() !== exp_q.size()) begin fails++; $display("FAIL gap_pulse_count mpl%0d: got %0d want %0d", mpl, pulse_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++) begin
            tests++;
            if (pulse_q[i] !== acc_edge[exp_q[i]] + 3) begin
                fails++;
                $display("FAIL gap_pulse_time mpl%0d #%0d: got edge %0d want %0d", mpl, i, pulse_q[i], acc_edge[exp_q[i]] + 3);
            end
        end
        tests++; if (corr_re !== exp_cre[36:0]) begin fails++; $display("FAIL gap_corr_re mpl%0d: got %0d want %0d", mpl, corr_re, exp_cre); end
        tests++; if (corr_im !== exp_cim[36:0]) begin fails++; $display("FAIL gap_corr_im mpl%0d: got %0d want %0d", mpl, corr_im, exp_cim); end
    endtask

    task automatic test_reset_after_pulse();
        min_power = 37'd1;
        min_plateau = 16'd32;
        load_stf(0, 160);
        do_reset();
        send_stream(64, 1, -1, 0, 9);
        tests++; if (pulse_q.size() !== 1) begin fails++; $display("FAIL rst_pre_pulse: got %0d want 1", pulse_q.size()); end
        do_reset();
        tests++; if (state_dbg !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        tests++; if (corr_re !== 37'd0) begin fails++; $display("FAIL rst_corr_re: got %0d want 0", corr_re); end
        send_stream(160, 1, -1, 0, 8);
        tests++; if (pulse_q.size() !== 1) begin fails++; $display("FAIL rst_replay_count: got %0d want 1", pulse_q.size()); end
        if (pulse_q.size() >= 1) begin
            tests++; if (pulse_q[0] !== acc_edge[63] + 3) begin fails++; $display("FAIL rst_replay_time: got %0d want %0d", pulse_q[0], acc_edge[63] + 3); end
        end
    endtask

    task automatic test_plateau_zero();
        min_power = 37'd1;
        min_plateau = 16'd0;
        load_stf(0, 64);
        do_reset();
        send_stream(64, 1, -1, 0, 8);
        tests++; if (pulse_q.size() !== 1) begin fails++; $display("FAIL plat0_count: got %0d want 1", pulse_q.size()); end
        if (pulse_q.size() >= 1) begin
            tests++; if (pulse_q[0] !== acc_edge[32] + 3) begin fails++; $display("FAIL plat0_time: got %0d want %0d", pulse_q[0], acc_edge[32] + 3); end
        end
    endtask

    task automatic test_power_threshold();
        // The period power is far below 2^36, so no sample may match.
        min_power = 37'h10_0000_0000;
        min_plateau = 16'd1;
        load_stf(0, 96);
        do_reset();
        send_stream(96, 1, -1, 0, 8);
        tests++; if (pulse_q.size() !== 0) begin fails++; $display("FAIL minpow_pulse: got %0d want 0", pulse_q.size()); end
        tests++; if (ms_cnt !== 64) begin fails++; $display("FAIL minpow_metric: got %0d want 64", ms_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        enable = 1'b0;
        sample_in = '0;
        sample_in_strobe = 1'b0;
        min_power = 37'd1;
        min_plateau = 16'd32;
        test_reset();
        test_stf_single(1, -1, 0);
        test_zeros();
        test_gap_recovery(32);
        test_gap_recovery(4);
        test_reset_after_pulse();
        test_stf_single(3, 63, 7);
        test_stf_single(3, 40, 7);
        test_plateau_zero();
        test_power_threshold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
